serial_sub_n: RTL

SERIAL_SUB_N -- requirements
Module: serial_sub_n

---
 rtl/serial_sub_n.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_sub_n.sv
// Digit-serial subtractor: d = x - y - bin, DIGIT bits per cycle, LSB slice first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, y_q, r_q, r_d, d_q;
  logic             borrow_q, borrow_d, bout_q;
  logic [WIDTH-1:0] x_sh, y_sh, slice_ext;
  logic [DIGIT:0]   diff;
  logic             last;

  // One slice per cycle; the top bit of the widened difference is the slice borrow.
  always_comb begin
    x_sh      = x_q >> (cnt_q * DIGIT);
    y_sh      = y_q >> (cnt_q * DIGIT);
    diff      = {1'b0, x_sh[DIGIT-1:0]} - {1'b0, y_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    borrow_d  = diff[DIGIT];
    slice_ext = WIDTH'(diff[DIGIT-1:0]);
    r_d       = r_q | (slice_ext << (cnt_q * DIGIT));
    last      = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && start) begin
        x_q      <= x;
        y_q      <= y;
        r_q      <= '0;
        borrow_q <= bin;
      end else if (state_q == StRun) begin
        r_q      <= r_d;
        borrow_q <= borrow_d;
        if (last) begin
          d_q    <= r_d;
          bout_q <= borrow_d;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last) begin
      ovf_q <= (x_q[WIDTH-1] != y_q[WIDTH-1]) && (r_d[WIDTH-1] != x_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign d    = d_q;
  assign bout = bout_q;

endmodule
